// File: rtl/ram_io_responder_if.sv
// Byte-wide memory bus between the MemCtrl initiator and the RAM/IO responder.
interface ram_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a, mem_dout, mem_wr,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr,
        output mem_din, io_buffer_full
    );
endinterface

// File: rtl/ram_io_responder.sv
// Responder for the MemCtrl byte bus: main RAM plus an IO window at mem_a[17:16]==2'b11
// holding UART TX/RX FIFOs, a status byte and a sticky halt flag. Reads return one cycle later.
module ram_io_responder #(
    parameter int ADDR_BITS = 17,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    ram_io_responder_if.slave       bus,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_ready,
    output logic                    halt,
    output logic                    tx_overflow
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TCW = TXW + 1;
    localparam int RCW = RXW + 1;
    localparam logic [TCW-1:0] TX_FULL   = TCW'(TX_DEPTH);
    localparam logic [TCW-1:0] TX_ALMOST = TCW'(TX_DEPTH - 2);
    localparam logic [RCW-1:0] RX_FULL   = RCW'(RX_DEPTH);

    logic [7:0] ram    [2**ADDR_BITS];
    logic [7:0] tx_mem [TX_DEPTH];
    logic [7:0] rx_mem [RX_DEPTH];

    logic [TXW-1:0] tx_wp, tx_rp;
    logic [TCW-1:0] tx_count;
    logic [RXW-1:0] rx_wp, rx_rp;
    logic [RCW-1:0] rx_count;

    logic                 io_sel, io_data, io_stat;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 ram_we, bus_rd;
    logic                 tx_full, tx_push_req, tx_push, tx_pop;
    logic                 rx_empty, rx_push, rx_pop;
    logic [7:0]           rd_data;
    logic                 unused_addr;

    // Only bits 17:16, 2:0 and the RAM index are decoded; the rest alias.
    always_comb begin
        unused_addr = ^bus.mem_a;
        io_sel      = (bus.mem_a[17:16] == 2'b11);
        io_data     = io_sel && (bus.mem_a[2:0] == 3'd0);
        io_stat     = io_sel && (bus.mem_a[2:0] == 3'd4);
        ram_idx     = bus.mem_a[ADDR_BITS-1:0];
        ram_we      = rdy && bus.mem_wr && !io_sel;
        bus_rd      = rdy && !bus.mem_wr;
    end

    always_comb begin
        tx_full     = (tx_count == TX_FULL);
        tx_valid    = (tx_count != '0);
        tx_data     = tx_mem[tx_rp];
        tx_push_req = rdy && bus.mem_wr && io_data;
        tx_push     = tx_push_req && !tx_full;
        tx_pop      = tx_valid && tx_ready;
        rx_empty    = (rx_count == '0);
        rx_ready    = (rx_count != RX_FULL);
        rx_push     = rx_valid && rx_ready;
        rx_pop      = bus_rd && io_data && !rx_empty;
    end

    always_comb begin
        rd_data = '0;
        if (!io_sel)
            rd_data = ram[ram_idx];
        else if (io_data)
            rd_data = rx_empty ? '0 : rx_mem[rx_rp];
        else if (io_stat)
            rd_data = {6'b0, bus.io_buffer_full, !rx_empty};
    end

    // Storage arrays carry no reset so the RAM survives rst_n.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_idx] <= bus.mem_dout;
        if (tx_push)
            tx_mem[tx_wp] <= bus.mem_dout;
        if (rx_push)
            rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_din        <= '0;
            bus.io_buffer_full <= 1'b0;
            halt               <= 1'b0;
            tx_overflow        <= 1'b0;
            tx_wp              <= '0;
            tx_rp              <= '0;
            tx_count           <= '0;
            rx_wp              <= '0;
            rx_rp              <= '0;
            rx_count           <= '0;
        end else begin
            if (bus_rd)
                bus.mem_din <= rd_data;
            bus.io_buffer_full <= (tx_count >= TX_ALMOST);
            if (rdy && bus.mem_wr && io_stat)
                halt <= 1'b1;
            if (tx_push_req && tx_full)
                tx_overflow <= 1'b1;
            tx_wp    <= tx_wp + TXW'(tx_push);
            tx_rp    <= tx_rp + TXW'(tx_pop);
            tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
            rx_wp    <= rx_wp + RXW'(rx_push);
            rx_rp    <= rx_rp + RXW'(rx_pop);
            rx_count <= rx_count + RCW'(rx_push) - RCW'(rx_pop);
        end
    end
endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: directed steps plus a random phase, checked every cycle
// against a queue-based reference model.
module tb_ram_io_responder;
    localparam int AB  = 17;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy = 1'b0;
    logic       tx_ready = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid, rx_ready, halt, tx_overflow;
    logic [7:0] tx_data;

    ram_io_responder_if bus();

    ram_io_responder #(.ADDR_BITS(AB), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .bus         (bus),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .halt        (halt),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram_m [int];
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    logic [7:0] drained [$];
    logic [7:0] m_din = 8'h00;
    bit         m_full = 1'b0;
    bit         m_halt = 1'b0;
    bit         m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mem_din", bus.mem_din, m_din);
        chk("io_buffer_full", bus.io_buffer_full, m_full);
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0)
            chk("tx_data", tx_data, txq[0]);
        chk("rx_ready", rx_ready, rxq.size() != RXD);
        chk("halt", halt, m_halt);
        chk("tx_overflow", tx_overflow, m_ovf);
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_din  = 8'h00;
        m_full = 1'b0;
        m_halt = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Apply one bus cycle, advance the model, cross the edge and compare.
    task automatic step(input bit r, input bit wr, input logic [31:0] a, input logic [7:0] d);
        bit        txpop, rxpush, txpush, nfull, io;
        int        off;
        int        idx;
        rdy          = r;
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.mem_wr   = wr;
        if (tx_valid && tx_ready)
            drained.push_back(tx_data);
        txpop  = tx_ready && (txq.size() > 0);
        rxpush = rx_valid && (rxq.size() < RXD);
        nfull  = (txq.size() >= TXD - 2);
        txpush = 1'b0;
        if (r) begin
            io  = (a[17:16] == 2'b11);
            off = int'(a[2:0]);
            idx = int'(a[AB-1:0]);
            if (wr) begin
                if (!io) ram_m[idx] = d;
                else if (off == 0) begin
                    if (txq.size() == TXD) m_ovf = 1'b1;
                    else txpush = 1'b1;
                end else if (off == 4) m_halt = 1'b1;
            end else begin
                if (!io) m_din = ram_m[idx];
                else if (off == 0) m_din = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                else if (off == 4) m_din = {6'b0, m_full, rxq.size() != 0};
                else m_din = 8'h00;
            end
        end
        if (txpop) void'(txq.pop_front());
        if (txpush) txq.push_back(d);
        if (rxpush) rxq.push_back(rx_data);
        m_full = nfull;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    logic [31:0] ra;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_a = '0;
        bus.mem_dout = '0;
        bus.mem_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_rx_ready", rx_ready, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++)
            step(1'b1, 1'b1, 32'h100 + i, 8'($urandom()));

        step(1'b1, 1'b1, 32'h00010, 8'hA5);
        step(1'b1, 1'b1, 32'h00011, 8'h5A);
        step(1'b1, 1'b0, 32'h00010, 8'h00);
        chk("rd_0x10", bus.mem_din, 8'hA5);
        step(1'b1, 1'b0, 32'h00011, 8'h00);
        chk("rd_0x11", bus.mem_din, 8'h5A);

        step(1'b1, 1'b1, 32'h30000, 8'h41);
        step(1'b1, 1'b1, 32'h30000, 8'h42);
        idle();
        drained.delete();
        tx_ready = 1'b1;
        repeat (3) idle();
        tx_ready = 1'b0;
        chk("tx2_count", drained.size(), 2);
        chk("tx2_first", drained[0], 8'h41);
        chk("tx2_second", drained[1], 8'h42);
        chk("tx2_valid_low", tx_valid, 1'b0);

        for (int i = 0; i < 14; i++)
            step(1'b1, 1'b1, 32'h30000, 8'(i));
        chk("full_lag", bus.io_buffer_full, 1'b0);
        idle();
        chk("full_after_14", bus.io_buffer_full, 1'b1);
        for (int i = 14; i < 17; i++)
            step(1'b1, 1'b1, 32'h30000, 8'(i));
        chk("overflow_set", tx_overflow, 1'b1);
        drained.delete();
        tx_ready = 1'b1;
        repeat (20) idle();
        tx_ready = 1'b0;
        chk("drain_count", drained.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("drain_order", drained[i], 8'(i));

        rx_data  = 8'h33;
        rx_valid = 1'b1;
        idle();
        rx_valid = 1'b0;
        step(1'b1, 1'b0, 32'h30004, 8'h00);
        chk("status_rx", bus.mem_din, 8'h01);
        step(1'b1, 1'b0, 32'h30000, 8'h00);
        chk("rx_pop", bus.mem_din, 8'h33);
        step(1'b1, 1'b0, 32'h30000, 8'h00);
        chk("rx_empty", bus.mem_din, 8'h00);

        step(1'b0, 1'b1, 32'h30004, 8'h00);
        chk("halt_rdy0", halt, 1'b0);
        step(1'b1, 1'b1, 32'h30004, 8'h00);
        chk("halt_set", halt, 1'b1);
        repeat (3) idle();
        chk("halt_sticky", halt, 1'b1);

        for (int i = 0; i < 400; i++) begin
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 2) == 0);
            rx_data  = 8'($urandom());
            if ($urandom_range(0, 1) == 0) begin
                ra = ($urandom() & 32'hFFFE_0000) | (32'h100 + $urandom_range(0, 63));
            end else begin
                ra = ($urandom() & 32'hFFFC_FFF8) | 32'h0003_0000;
                case ($urandom_range(0, 3))
                    1: ra = ra | 32'h4;
                    2: ra = ra | ($urandom() & 32'h7);
                    default: ;
                endcase
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, 8'($urandom()));
        end

        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (20) idle();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 32'h30000, 8'(8'h60 + i));
        step(1'b1, 1'b0, 32'h100, 8'h00);
        step(1'b1, 1'b0, 32'h101, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_din", bus.mem_din, 8'h00);
        chk("rst_full", bus.io_buffer_full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_halt", halt, 1'b0);
        chk("rst_overflow", tx_overflow, 1'b0);
        model_reset();
        rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
        step(1'b1, 1'b0, 32'h00010, 8'h00);
        chk("ram_kept", bus.mem_din, 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
